bomb_timer: RTL and testbench
=============================

// Module: bomb_timer
//
// PURPOSE
// Consumer end of the 1 Hz time base: takes the clk_1s square wave (treated as
// data, not a clock) and runs the fuse/blast timing of one bomb. It resamples
// clk_1s into the clk_50 domain, extracts one tick per second, and sequences
// IDLE -> ARMED -> BLAST -> IDLE. It sits between the gameplay logic, which
// plants bombs and raises chain reactions, and the display logic, which draws
// the fuse and explosion. One instance is used per bomb slot.
//
// PARAMETERS
// FUSE_S   3   fuse length in ticks; loaded into the counter on plant (>=1)
// BLAST_S  1   explosion length in ticks (>=1)
// CNT_W    4   counter width; must hold max(FUSE_S, BLAST_S)
//
// PORTS
// clk_50        in   1      system clock, 50 MHz
// reset_n       in   1      asynchronous reset, active low
// clk_1s        in   1      1 Hz square wave from the divider, asynchronous to logic
// plant         in   1      1-cycle request to arm the bomb
// detonate      in   1      chain reaction: forces an immediate explosion
// armed         out  1      high in ARMED
// blast         out  1      high in BLAST
// done          out  1      1-cycle pulse on the BLAST->IDLE transition
// seconds_left  out  CNT_W  current counter value; 0 in IDLE
//
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - state=IDLE; armed, blast, done and seconds_left all 0.
//   - The 2-FF sync chain and the edge register reset to 1, so a rising edge
//     needs a 0 sample first. No false tick at reset release, whatever the
//     level of clk_1s.
// - Tick extraction:
//   - s1 <= clk_1s; s2 <= s1; s3 <= s2; tick = s2 & ~s3.
//   - tick is high for exactly 1 clk_50 cycle, 3 cycles after the clk_1s rise.
//   - tick is internal only.
// - State machine (all outputs registered):
//   - IDLE:
//     - plant -> ARMED, cnt <= FUSE_S.
//     - tick and detonate are ignored.
//   - ARMED:
//     - detonate -> BLAST, cnt <= BLAST_S. Detonate has priority over a tick in
//       the same cycle.
//     - else tick with cnt>1 -> cnt <= cnt-1.
//     - else tick with cnt==1 -> BLAST, cnt <= BLAST_S.
//     - plant is ignored.
//   - BLAST:
//     - tick with cnt>1 -> cnt <= cnt-1.
//     - tick with cnt==1 -> IDLE, cnt <= 0, done=1 for the following cycle.
//     - plant and detonate are ignored.
// - Fuse timing:
//   - The first tick after plant may come at any phase, so the fuse lasts
//     between FUSE_S-1 and FUSE_S seconds. Equal to FUSE_S when plant falls in
//     the cycle right after a tick.
//   - plant in the same cycle as a tick in IDLE: plant wins, and that tick is
//     not counted.
// - Output relationships:
//   - armed and blast are never both high.
//   - seconds_left equals cnt.
//   - done is exactly 1 cycle, coincident with the first IDLE cycle.
//   - plant on the cycle where done is high is accepted, since state is IDLE.
// - Reset mid-operation returns the block immediately to IDLE with all
//   outputs 0, and no done pulse.
// - cnt never wraps: decrement happens only when cnt>1.
//
// TESTING
// The bench drives clk_1s as a fast square wave with a 40-cycle period, high
// for 20 cycles, and uses FUSE_S=3, BLAST_S=2.
// 1. Reset with clk_1s high, release, no plant -> armed=blast=done=0 and
//    seconds_left=0 for 200 cycles, with no spurious state change.
// 2. plant 1 cycle after a tick -> seconds_left 3,2,1 with one step per tick;
//    blast=1 with seconds_left=2; then 1; then done pulses for 1 cycle,
//    state IDLE. Total 5 ticks.
// 3. plant and tick in the same cycle -> seconds_left stays 3 until the
//    following tick (that tick is not counted).
// 4. detonate while seconds_left=2 together with a tick -> next cycle blast=1,
//    seconds_left=2, armed=0.
// 5. plant during ARMED and during BLAST, and detonate in IDLE -> no effect on
//    state or count. plant on the done cycle -> armed=1, seconds_left=3 the
//    next cycle.
// 6. reset_n pulsed low mid-BLAST -> all outputs 0 asynchronously; no done
//    pulse; the next plant runs a full sequence normally.

Source files
------------

// File: rtl/bomb_timer.sv
// Fuse/blast sequencer for one bomb slot, paced by the 1 Hz clk_1s level.
// clk_1s is resampled into clk_50 and edge-detected into a single-cycle tick.
module bomb_timer #(
    parameter int FUSE_S  = 3,
    parameter int BLAST_S = 1,
    parameter int CNT_W   = 4
) (
    input  logic             clk_50,
    input  logic             reset_n,
    input  logic             clk_1s,
    input  logic             plant,
    input  logic             detonate,
    output logic             armed,
    output logic             blast,
    output logic             done,
    output logic [CNT_W-1:0] seconds_left
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] BLAST = 2'd2;

    localparam logic [CNT_W-1:0] FUSE_LD  = CNT_W'(FUSE_S);
    localparam logic [CNT_W-1:0] BLAST_LD = CNT_W'(BLAST_S);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic             s1, s2, s3;
    logic             tick;
    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt_n;
    logic             done_n;

    // Chain resets high so a rising edge needs a real 0 sample first.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= clk_1s;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    always_comb begin
        state_n = state;
        cnt_n   = seconds_left;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (plant) begin
                    state_n = ARMED;
                    cnt_n   = FUSE_LD;
                end
            end
            ARMED: begin
                if (detonate) begin
                    state_n = BLAST;
                    cnt_n   = BLAST_LD;
                end else if (tick) begin
                    if (seconds_left > ONE) begin
                        cnt_n = seconds_left - ONE;
                    end else begin
                        state_n = BLAST;
                        cnt_n   = BLAST_LD;
                    end
                end
            end
            BLAST: begin
                if (tick) begin
                    if (seconds_left > ONE) begin
                        cnt_n = seconds_left - ONE;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Flags are registered from the next state so they line up with the count.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            seconds_left <= '0;
            armed        <= 1'b0;
            blast        <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            seconds_left <= cnt_n;
            armed        <= (state_n == ARMED);
            blast        <= (state_n == BLAST);
            done         <= done_n;
        end
    end

endmodule

// File: tb/tb_bomb_timer.sv
// Bench for bomb_timer: behavioural model compared every cycle, directed
// scenarios with literal expectations, then a randomized plant/detonate/reset run.
module tb_bomb_timer;
    localparam int FUSE = 3;
    localparam int BL   = 2;
    localparam int CW   = 4;
    localparam int M_IDLE = 0, M_ARMED = 1, M_BLAST = 2;

    logic clk_50 = 1'b0;
    logic reset_n = 1'b1;
    logic clk_1s = 1'b1;
    logic plant = 1'b0;
    logic detonate = 1'b0;
    logic armed, blast, done;
    logic [CW-1:0] seconds_left;

    int checks = 0;
    int errors = 0;

    bomb_timer #(.FUSE_S(FUSE), .BLAST_S(BL), .CNT_W(CW)) dut (
        .clk_50(clk_50), .reset_n(reset_n), .clk_1s(clk_1s),
        .plant(plant), .detonate(detonate),
        .armed(armed), .blast(blast), .done(done),
        .seconds_left(seconds_left)
    );

    always #5 clk_50 = ~clk_50;

    // Fast stand-in for the 1 Hz wave: 40-cycle period, 20 high.
    int ph = 0;
    always @(negedge clk_50) begin
        ph     <= (ph + 1) % 40;
        clk_1s <= ((ph + 1) % 40) < 20;
    end

    // Reference model: samp holds the last three clk_1s samples, newest in bit 0.
    logic [2:0] samp = 3'b111;
    int  m_mode = M_IDLE;
    int  m_left = 0;
    bit  m_done = 1'b0;
    wire m_tick = samp[1] & ~samp[2];

    always @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            samp   <= 3'b111;
            m_mode <= M_IDLE;
            m_left <= 0;
            m_done <= 1'b0;
        end else begin
            samp   <= {samp[1:0], clk_1s};
            m_done <= 1'b0;
            if (m_mode == M_IDLE) begin
                if (plant) begin m_mode <= M_ARMED; m_left <= FUSE; end
            end else if (m_mode == M_ARMED) begin
                if (detonate || (m_tick && m_left == 1)) begin
                    m_mode <= M_BLAST; m_left <= BL;
                end else if (m_tick) begin
                    m_left <= m_left - 1;
                end
            end else if (m_tick) begin
                if (m_left > 1) m_left <= m_left - 1;
                else begin m_mode <= M_IDLE; m_left <= 0; m_done <= 1'b1; end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_50) begin
        chk("armed", int'(armed), int'(m_mode == M_ARMED));
        chk("blast", int'(blast), int'(m_mode == M_BLAST));
        chk("done", int'(done), int'(m_done));
        chk("seconds_left", int'(seconds_left), m_left);
        chk("armed_blast_excl", int'(armed & blast), 0);
    end

    task automatic step();
        @(negedge clk_50);
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!m_tick && n < 100) begin step(); n++; end
        if (!m_tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 400) begin step(); n++; end
        chk("done_wait", int'(done), 1);
    endtask

    initial begin
        int ticks, n;
        #1 reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;

        // Idle after reset with clk_1s high: nothing moves
        repeat (200) step();
        chk("idle_armed", int'(armed), 0);
        chk("idle_secs", int'(seconds_left), 0);
        detonate = 1'b1; step(); detonate = 1'b0;
        chk("idle_detonate_blast", int'(blast), 0);

        // Plant one cycle after a tick: full 5-tick sequence
        step(); wait_tick(); step();
        plant = 1'b1; step(); plant = 1'b0;
        chk("plant_armed", int'(armed), 1);
        chk("plant_secs", int'(seconds_left), 3);
        ticks = 0; n = 0;
        while (!done && n < 400) begin
            if (m_tick) ticks++;
            step(); n++;
        end
        chk("seq_done", int'(done), 1);
        chk("seq_ticks", ticks, 5);
        step();
        chk("done_one_cycle", int'(done), 0);
        chk("after_done_secs", int'(seconds_left), 0);

        // Plant together with a tick: that tick is not counted
        wait_tick();
        plant = 1'b1; step(); plant = 1'b0;
        chk("same_tick_secs", int'(seconds_left), 3);
        step(); wait_tick();
        chk("held_secs", int'(seconds_left), 3);
        step();
        chk("first_count_secs", int'(seconds_left), 2);

        // Detonate with seconds_left=2 on a tick
        step(); wait_tick();
        detonate = 1'b1; step(); detonate = 1'b0;
        chk("det_blast", int'(blast), 1);
        chk("det_armed", int'(armed), 0);
        chk("det_secs", int'(seconds_left), 2);

        // Plant ignored in BLAST; plant on done cycle accepted; ignored in ARMED
        plant = 1'b1; step(); plant = 1'b0;
        chk("blast_plant_secs", int'(seconds_left), 2);
        wait_done();
        plant = 1'b1; step(); plant = 1'b0;
        chk("done_plant_armed", int'(armed), 1);
        chk("done_plant_secs", int'(seconds_left), 3);
        plant = 1'b1; step(); plant = 1'b0;
        chk("armed_plant_secs", int'(seconds_left), 3);

        // Reset mid-BLAST
        n = 0;
        while (!blast && n < 400) begin step(); n++; end
        chk("reach_blast", int'(blast), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_blast", int'(blast), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_secs", int'(seconds_left), 0);
        step(); reset_n = 1'b1;
        step();
        chk("rst_no_done", int'(done), 0);
        plant = 1'b1; step(); plant = 1'b0;
        chk("rst_replant_secs", int'(seconds_left), 3);
        wait_done();

        // Randomized plant/detonate with rare resets
        repeat (3000) begin
            plant    = ($urandom_range(19) == 0);
            detonate = ($urandom_range(29) == 0);
            reset_n  = ($urandom_range(799) != 0);
            step();
        end
        plant = 1'b0; detonate = 1'b0; reset_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
